cond_writeback_stage: RTL

Execute-to-writeback stage that sits directly downstream of the ALU. It evaluates the ARM condition field of each instruction against the current CPSR flags. It commits the ALU flags to the CPSR when the instruction passes and sets S, and registers the ALU result for a register-file write. It also keeps retired and condition-failed instruction counters for debug.

---
 rtl/arm_pkg.sv | 54 +++++
 rtl/cond_eval.sv | 41 ++++
 rtl/cond_writeback_stage.sv | 79 +++++++
 3 files changed

// File: rtl/arm_pkg.sv
// Shared ARM execute/writeback definitions: condition codes, flag bit positions, ALU opcodes.
// Pure declarations, no logic or latency.
// No flow control of its own.
package arm_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Flags are packed {V,N,C,Z}.
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    localparam logic [4:0] ALU_AND = 5'h00;
    localparam logic [4:0] ALU_EOR = 5'h01;
    localparam logic [4:0] ALU_SUB = 5'h02;
    localparam logic [4:0] ALU_RSB = 5'h03;
    localparam logic [4:0] ALU_ADD = 5'h04;
    localparam logic [4:0] ALU_ADC = 5'h05;
    localparam logic [4:0] ALU_SBC = 5'h06;
    localparam logic [4:0] ALU_RSC = 5'h07;
    localparam logic [4:0] ALU_TST = 5'h08;
    localparam logic [4:0] ALU_TEQ = 5'h09;
    localparam logic [4:0] ALU_CMP = 5'h0a;
    localparam logic [4:0] ALU_CMN = 5'h0b;
    localparam logic [4:0] ALU_ORR = 5'h0c;
    localparam logic [4:0] ALU_MOV = 5'h0d;
    localparam logic [4:0] ALU_BIC = 5'h0e;
    localparam logic [4:0] ALU_MVN = 5'h0f;
    localparam logic [4:0] ALU_MUL = 5'h10;
    localparam logic [4:0] ALU_MLA = 5'h11;

    // Header half of the writeback register; the data word travels beside it.
    typedef struct packed {
        logic       we;
        logic [3:0] waddr;
    } wb_hdr_t;

endpackage

// File: rtl/cond_eval.sv
// ARM condition-field evaluator against a {V,N,C,Z} flag set.
// Combinational, zero latency.
// No flow control; consumer qualifies pass with its own handshake.
module cond_eval
    import arm_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic z, c, n, v;

    always_comb begin
        z = flags[FLAG_Z];
        c = flags[FLAG_C];
        n = flags[FLAG_N];
        v = flags[FLAG_V];
        pass = 1'b0;
        unique case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_writeback_stage.sv
// Execute-to-writeback: condition check, CPSR commit, registered RF write, debug counters.
// Latency: CPSR and rf_we visible one cycle after accept.
// Backpressure: stall freezes all state and masks rf_we; in_ready = ~stall.
module cond_writeback_stage
    import arm_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        cond,
    input  logic              s_bit,
    input  logic [3:0]        rd,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    input  logic              alu_wb,
    input  logic              stall,
    output logic              rf_we,
    output logic [3:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [3:0]        cpsr_flags,
    output logic [CNT_W-1:0]  retired_cnt,
    output logic [CNT_W-1:0]  fail_cnt
);

    logic              pass;
    logic              accept;
    logic [3:0]        cpsr_q;
    wb_hdr_t           hdr_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  retired_q;
    logic [CNT_W-1:0]  fail_q;

    cond_eval u_cond_eval (
        .cond  (cond),
        .flags (cpsr_q),
        .pass  (pass)
    );

    assign in_ready = ~stall;
    assign accept   = in_valid & ~stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpsr_q    <= '0;
            hdr_q     <= '0;
            data_q    <= '0;
            retired_q <= '0;
            fail_q    <= '0;
        end else if (!stall) begin
            if (accept) begin
                if (pass && s_bit) begin
                    cpsr_q <= alu_flags;
                end
                hdr_q.we    <= pass & alu_wb;
                hdr_q.waddr <= rd;
                data_q      <= alu_result;
                retired_q   <= retired_q + CNT_W'(1);
                if (!pass) begin
                    fail_q <= fail_q + CNT_W'(1);
                end
            end else begin
                // Address and data are left as-is so the bus stays quiet between writes.
                hdr_q.we <= 1'b0;
            end
        end
    end

    assign rf_we       = hdr_q.we & ~stall;
    assign rf_waddr    = hdr_q.waddr;
    assign rf_wdata    = data_q;
    assign cpsr_flags  = cpsr_q;
    assign retired_cnt = retired_q;
    assign fail_cnt    = fail_q;

endmodule
